// File: rtl/load_store_unit.sv
// Byte/half/word load-store engine onto a 32-bit synchronous RAM; define LSU_MISALIGN_EN for two-beat word-crossing accesses.
// Latency: load 3 cycles (split 4), store 2 cycles (split 3) from acceptance to rsp_valid; one request in flight.
// Backpressure: req_ready only in IDLE; the response pulse cannot be stalled.
module load_store_unit (
    input  logic        clk,
    input  logic        rts,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_DATA, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, word0_q, rdata_q;

    logic [1:0]  a;
    logic [3:0]  base_be;
    logic [7:0]  be8;
    logic        split, reject;
    logic [63:0] wdata64;
    logic [29:0] word0_addr, word1_addr;
    logic [31:0] lo_word, hi_word, load_raw, load_ext;

    assign a          = addr_q[1:0];
    assign be8        = {4'h0, base_be} << a;
    assign split      = |be8[7:4];
    assign wdata64    = {32'h0, wdata_q} << {a, 3'b000};
    assign word0_addr = addr_q[31:2];
    assign word1_addr = addr_q[31:2] + 30'd1;

    always_comb begin
        base_be = 4'hF;
        case (size_q)
            2'd0:    base_be = 4'h1;
            2'd1:    base_be = 4'h3;
            default: base_be = 4'hF;
        endcase
    end

`ifdef LSU_MISALIGN_EN
    assign reject  = 1'b0;
    assign rsp_err = 1'b0;
`else
    logic err_q;

    assign reject  = split;
    assign rsp_err = err_q;

    // Only a rejected split reaches RESP with split set in this build.
    always_ff @(posedge clk) begin
        if (rts) begin
            err_q <= 1'b0;
        end else if (state_d == S_RESP) begin
            err_q <= split;
        end
    end
`endif

    // For split loads word0 was captured during ACC1 and word1 is on the bus now.
    always_comb begin
        lo_word  = split ? word0_q : mem_rdata;
        hi_word  = split ? mem_rdata : 32'h0;
        load_raw = 32'({hi_word, lo_word} >> {a, 3'b000});
        case (size_q)
            2'd0:    load_ext = {{24{~uns_q & load_raw[7]}}, load_raw[7:0]};
            2'd1:    load_ext = {{16{~uns_q & load_raw[15]}}, load_raw[15:0]};
            default: load_ext = load_raw;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid) state_d = S_ACC0;
            S_ACC0: begin
                if (split) state_d = reject ? S_RESP : S_ACC1;
                else       state_d = we_q ? S_RESP : S_DATA;
            end
            S_ACC1:  state_d = we_q ? S_RESP : S_DATA;
            S_DATA:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 30'h0;
        mem_be    = 4'h0;
        mem_wdata = 32'h0;
        case (state_q)
            S_ACC0: begin
                if (!reject) begin
                    mem_en    = 1'b1;
                    mem_we    = we_q;
                    mem_addr  = word0_addr;
                    mem_be    = be8[3:0];
                    mem_wdata = wdata64[31:0];
                end
            end
            S_ACC1: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = word1_addr;
                mem_be    = be8[7:4];
                mem_wdata = wdata64[63:32];
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (rts) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            word0_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (req_valid && req_ready) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == S_ACC1) begin
                word0_q <= mem_rdata;
            end
            if (state_d == S_RESP) begin
                rdata_q <= (state_q == S_DATA) ? load_ext : 32'h0;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference memory, word RAM model, directed and random requests.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rts = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    load_store_unit dut (
        .clk(clk), .rts(rts),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Word RAM indexed by the low 8 word-address bits; the bench never uses aliasing words.
    logic [31:0] ram [0:255];
    logic        poke_en = 1'b0;
    logic [29:0] poke_addr = 30'h0;
    logic [31:0] poke_dat = 32'h0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (poke_en) ram[poke_addr[7:0]] <= poke_dat;
        if (mem_en && mem_we) ram[mem_addr[7:0]] <= merge(ram[mem_addr[7:0]], mem_wdata, mem_be);
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[7:0]];
    end

    // Reference model: flat byte-addressed memory.
    logic [7:0] ref_mem [bit [31:0]];

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic        tr_en    [1:8];
    logic [29:0] tr_addr  [1:8];
    logic [3:0]  tr_be    [1:8];
    logic [31:0] tr_wdata [1:8];
    logic [31:0] last_rd;
    logic        last_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [29:0] w, input logic [31:0] v);
        poke_en   = 1'b1;
        poke_addr = w;
        poke_dat  = v;
        for (int i = 0; i < 4; i++) ref_mem[32'({w, 2'b00} + i)] = v[8*i +: 8];
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd, input string tag);
        int n, lat, acc, exp_lat, exp_acc;
        logic spl, rej;
        logic [31:0] exp_rd;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        spl = (int'(addr[1:0]) + n) > 4;
`ifdef LSU_MISALIGN_EN
        rej = 1'b0;
`else
        rej = spl;
`endif
        exp_acc = rej ? 0 : (spl ? 2 : 1);
        exp_lat = rej ? 2 : exp_acc + (we ? 1 : 2);
        exp_rd  = 32'h0;
        if (!rej && !we) begin
            for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = ref_rd(32'(addr + i));
            if (!uns && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | ~((32'h1 << (8*n)) - 32'h1);
        end
        if (!rej && we) begin
            for (int i = 0; i < n; i++) ref_mem[32'(addr + i)] = wd[8*i +: 8];
        end
        for (int c = 1; c <= 8; c++) begin
            tr_en[c] = 1'b0; tr_addr[c] = 30'h0; tr_be[c] = 4'h0; tr_wdata[c] = 32'h0;
        end

        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = sz;
        req_unsigned = uns; req_wdata = wd;
        check({tag, " ready_idle"}, 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
        req_size = 2'($urandom); req_unsigned = 1'($urandom); req_wdata = $urandom;

        lat = 0; acc = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            tr_en[c] = mem_en; tr_addr[c] = mem_addr; tr_be[c] = mem_be; tr_wdata[c] = mem_wdata;
            if (mem_en) acc++;
            if (rsp_valid) begin
                lat = c; last_rd = rsp_rdata; last_err = rsp_err;
                check({tag, " ready_in_resp"}, 32'(req_ready), 32'h0);
            end else begin
                @(posedge clk); #1;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " accesses"}, 32'(acc), 32'(exp_acc));
        check({tag, " rdata"}, last_rd, exp_rd);
        check({tag, " err"}, 32'(last_err), 32'(rej));
        @(posedge clk); #1;
        check({tag, " pulse_end"}, 32'(rsp_valid), 32'h0);
        check({tag, " ready_back"}, 32'(req_ready), 32'h1);
        check({tag, " rdata_hold"}, rsp_rdata, exp_rd);
    endtask

    initial begin
        int acc, seen;
        logic [31:0] ra;

        // Reset with a request pending: it must not be accepted.
        req_valid = 1'b1; req_addr = 32'h4; req_size = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        check("rst ready", 32'(req_ready), 32'h1);
        check("rst rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);
        check("rst rsp_err", 32'(rsp_err), 32'h0);
        check("rst mem_en", 32'(mem_en), 32'h0);
        check("rst mem_we", 32'(mem_we), 32'h0);
        check("rst mem_addr", 32'(mem_addr), 32'h0);
        check("rst mem_be", 32'(mem_be), 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        rts = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        check("rst no_accept", 32'(mem_en), 32'h0);

        poke(30'h0, 32'h8899AABB);
        do_req(1'b0, 32'h3, 2'd0, 1'b0, 32'h0, "lb_s3");
        check("lb_s3 be", 32'(tr_be[1]), 32'h8);
        check("lb_s3 value", last_rd, 32'hFFFFFF88);

        poke(30'h0, 32'h12345678);
        do_req(1'b0, 32'h2, 2'd1, 1'b1, 32'h0, "lhu_2");
        check("lhu_2 value", last_rd, 32'h00001234);
        poke(30'h0, 32'h0000F00D);
        do_req(1'b0, 32'h0, 2'd1, 1'b0, 32'h0, "lh_0");
        check("lh_0 value", last_rd, 32'hFFFFF00D);

        do_req(1'b1, 32'h101, 2'd3, 1'b0, 32'hCAFEBABE, "sw_101");
`ifdef LSU_MISALIGN_EN
        check("sw_101 addr0", 32'(tr_addr[1]), 32'h40);
        check("sw_101 be0", 32'(tr_be[1]), 32'hE);
        check("sw_101 wdata0", tr_wdata[1], 32'hFEBABE00);
        check("sw_101 en1", 32'(tr_en[2]), 32'h1);
        check("sw_101 addr1", 32'(tr_addr[2]), 32'h41);
        check("sw_101 be1", 32'(tr_be[2]), 32'h1);
        check("sw_101 wdata1", tr_wdata[2], 32'h000000CA);
`else
        check("sw_101 no_en", 32'(tr_en[1]), 32'h0);
        check("sw_101 err", 32'(last_err), 32'h1);
`endif

        poke(30'h3FFFFFFF, 32'hAABB0000);
        poke(30'h0, 32'h0000CCDD);
        do_req(1'b0, 32'hFFFFFFFE, 2'd3, 1'b0, 32'h0, "lw_wrap");
`ifdef LSU_MISALIGN_EN
        check("lw_wrap addr0", 32'(tr_addr[1]), 32'h3FFFFFFF);
        check("lw_wrap addr1", 32'(tr_addr[2]), 32'h0);
        check("lw_wrap value", last_rd, 32'hCCDDAABB);
`else
        check("lw_wrap err", 32'(last_err), 32'h1);
`endif

        // Reset in the first beat of a split store.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h101; req_size = 2'd3;
        req_unsigned = 1'b0; req_wdata = 32'h11223344;
        @(posedge clk); #1;
        req_valid = 1'b0;
`ifdef LSU_MISALIGN_EN
        check("rstmid t1_en", 32'(mem_en), 32'h1);
        check("rstmid t1_be", 32'(mem_be), 32'hE);
        for (int i = 0; i < 3; i++) ref_mem[32'(32'h101 + i)] = req_wdata[8*i +: 8];
`else
        check("rstmid t1_en", 32'(mem_en), 32'h0);
`endif
        rts = 1'b1;
        @(posedge clk); #1;
        rts = 1'b0;
        check("rstmid ready", 32'(req_ready), 32'h1);
        acc = 0; seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (mem_en) acc++;
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        check("rstmid accesses", 32'(acc), 32'h0);
        check("rstmid rsp", 32'(seen), 32'h0);
        do_req(1'b0, 32'h100, 2'd3, 1'b0, 32'h0, "rstmid readback");

        for (int w = 0; w < 32; w++) poke(30'(w), $urandom);
        poke(30'h3FFFFFFE, $urandom);
        poke(30'h3FFFFFFF, $urandom);
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else                           ra = 32'($urandom_range(0, 127));
            do_req(1'($urandom), ra, 2'($urandom), 1'($urandom), $urandom, "rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
